bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_SRC, default 24: number of bus sources; one per mux_32_to_1 data input.
REQ-002 Parameter SEL_W, default 5: select width.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive owned cycles per grant, range 1..15.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-005 clear  in  1  reset, synchronous, active-high.
REQ-006 req  in  N_SRC  level request per source; bit i asks to drive the bus from data_i.
REQ-007 grant  out  N_SRC  one-hot or zero; registered.
REQ-008 select  out  SEL_W  index of the granted source; registered; drives the mux select.
REQ-009 bus_valid  out  1  high when bus_contents holds data from a granted source.
REQ-010 owner  out  SEL_W  index of the source whose data is on bus_contents while bus_valid is high.

Function
REQ-011 The block SHALL have two states: IDLE and OWN.
REQ-012 Internal state SHALL be a round-robin pointer ptr (SEL_W bits) and a burst counter cnt (4 bits).
REQ-013 Arbitration SHALL select the first set req bit searching ptr+1, ptr+2, ... and wrapping from N_SRC-1 to 0; ptr itself is searched last.
REQ-014 IDLE, any req set: at the edge, state -> OWN, select = winner, grant = 1<<winner, cnt = 1.
REQ-015 IDLE, req all zero: state stays IDLE, grant = 0, select holds its value.
REQ-016 OWN, req[select]=1 and cnt<MAX_BURST: at the edge, stay OWN, cnt = cnt+1, select and grant unchanged.
REQ-017 OWN, otherwise (req[select]=0 or cnt=MAX_BURST): at the edge, state -> IDLE, grant = 0, ptr = select, cnt = 0; select holds.
REQ-018 Every grant SHALL be followed by at least one IDLE cycle with grant = 0 (bus turnaround).
REQ-019 A continuously held request SHALL own for exactly MAX_BURST cycles per grant.
REQ-020 A request dropped during OWN SHALL end the grant at the next edge; the cycle in which it was sampled low still counts as owned.
REQ-021 Request bits other than req[select] SHALL be ignored during OWN.
REQ-022 select SHALL never take a value >= N_SRC.
REQ-023 grant SHALL have at most one bit set and SHALL equal 1<<select whenever nonzero.
REQ-024 Mux alignment: bus_valid and owner SHALL be registered copies of (state==OWN) and select, one cycle behind grant, matching the registered mux output.
REQ-025 Fairness: with K sources requesting continuously, each SHALL be granted once in every K consecutive grants.

Reset
REQ-026 When clear=1 at an edge: state = IDLE, grant = 0, select = 0, ptr = N_SRC-1, cnt = 0, bus_valid = 0, owner = 0.
REQ-027 clear SHALL take priority over all transitions, including mid-OWN; the aborted grant SHALL NOT update ptr from select.
REQ-028 The first arbitration after clear SHALL search from index 0.

Verification
REQ-029 Clear, then req=0 for 20 cycles -> grant=0, select=0, bus_valid=0 throughout.
REQ-030 req=0x000020 held -> grant=0x000020 and select=5 for 4 cycles; bus_valid=1 and owner=5 for 4 cycles, delayed by one; 1 idle cycle; pattern repeats.
REQ-031 req bits 3 and 20 held after clear -> grants 3,20,3,20,..., each 4 cycles, 1 idle cycle between grants.
REQ-032 Wrap-around: last grant 22, then req bits 1 and 23 held -> grant 23 first, then 1.
REQ-033 req bit 7 held for 2 cycles from its grant, then dropped -> grant lasts 2 cycles; bus_valid high for 2 cycles.
REQ-034 clear pulsed during the 2nd OWN cycle of source 9 while bits 2 and 9 are held -> next edge: grant=0, bus_valid=0; next grant goes to source 2.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter
//
// Round-robin arbiter for a shared bus built around a registered N:1 data mux.
// A source keeps the bus for at most MAX_BURST consecutive cycles per grant.
// Every grant is followed by at least one idle cycle with grant = 0 (turnaround).
// bus_valid/owner follow grant/select by one cycle so that they line up with
// the registered mux output.
//
// Ports
//   clk        in   1      single clock; all state updates on the rising edge
//   clear      in   1      synchronous active-high reset
//   req        in   N_SRC  level request per source
//   grant      out  N_SRC  one-hot or zero, registered
//   select     out  SEL_W  index of the granted source, registered (mux select)
//   bus_valid  out  1      registered copy of (state == OWN), one cycle behind grant
//   owner      out  SEL_W  registered copy of select, one cycle behind grant
module bus_arbiter #(
  parameter int unsigned N_SRC     = 24,
  parameter int unsigned SEL_W     = 5,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] grant,
  output logic [SEL_W-1:0] select,
  output logic             bus_valid,
  output logic [SEL_W-1:0] owner
);

  localparam logic [3:0]       MaxCnt  = 4'(MAX_BURST);
  localparam logic [SEL_W-1:0] PtrInit = SEL_W'(N_SRC - 1);

  typedef enum logic [0:0] {
    StIdle,
    StOwn
  } state_e;

  state_e           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [3:0]       cnt_q;
  logic [SEL_W-1:0] select_q;
  logic [N_SRC-1:0] grant_q;
  logic             bus_valid_q;
  logic [SEL_W-1:0] owner_q;

  // Round-robin search: ptr+1, ptr+2, ... wrapping at N_SRC, ptr itself last.
  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic [N_SRC-1:0] win_onehot;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= int'(N_SRC); k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= int'(N_SRC)) idx = idx - int'(N_SRC);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // Owner keeps the bus only while it still requests and has burst budget left.
  logic own_continue;
  assign own_continue = req[select_q] && (cnt_q < MaxCnt);

  always_ff @(posedge clk) begin
    if (clear) begin
      // An aborted grant must not advance ptr: reset wins over everything.
      state_q     <= StIdle;
      ptr_q       <= PtrInit;
      cnt_q       <= '0;
      select_q    <= '0;
      grant_q     <= '0;
      bus_valid_q <= 1'b0;
      owner_q     <= '0;
    end else begin
      // Data registered by the mux this edge came from the current select.
      bus_valid_q <= (state_q == StOwn);
      owner_q     <= select_q;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q  <= StOwn;
            select_q <= win_idx;
            grant_q  <= win_onehot;
            cnt_q    <= 4'd1;
          end else begin
            grant_q  <= '0;
          end
        end
        StOwn: begin
          if (own_continue) begin
            cnt_q <= cnt_q + 4'd1;
          end else begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= select_q;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign select    = select_q;
  assign bus_valid = bus_valid_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_bus_arbiter;

  localparam int N  = 24;
  localparam int SW = 5;
  localparam int MB = 4;

  logic          clk;
  logic          clear;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [SW-1:0] select;
  logic          bus_valid;
  logic [SW-1:0] owner;

  int total = 0;
  int bad   = 0;

  // Reference model state (plain integers).
  bit m_own;
  int m_sel, m_ptr, m_cnt, m_ow;
  bit m_bv;

  bus_arbiter #(
    .N_SRC    (N),
    .SEL_W    (SW),
    .MAX_BURST(MB)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .req      (req),
    .grant    (grant),
    .select   (select),
    .bus_valid(bus_valid),
    .owner    (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_edge(input logic [N-1:0] r, input logic c);
    if (c) begin
      m_own = 0; m_sel = 0; m_ptr = N - 1; m_cnt = 0; m_bv = 0; m_ow = 0;
    end else begin
      m_bv = m_own;
      m_ow = m_sel;
      if (!m_own) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (r[i]) begin
            m_own = 1; m_sel = i; m_cnt = 1;
            break;
          end
        end
      end else if (r[m_sel] && m_cnt < MB) begin
        m_cnt = m_cnt + 1;
      end else begin
        m_own = 0; m_ptr = m_sel; m_cnt = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0]  exp_g;
    logic [SW-1:0] exp_s, exp_o;
    logic          exp_v;
    exp_g = m_own ? (N'(1) << m_sel) : '0;
    exp_s = SW'(m_sel);
    exp_o = SW'(m_ow);
    exp_v = m_bv;
    total++;
    assert (grant === exp_g) else begin
      bad++; $error("FAIL grant: got %h want %h", grant, exp_g);
    end
    total++;
    assert (select === exp_s) else begin
      bad++; $error("FAIL select: got %0d want %0d", select, exp_s);
    end
    total++;
    assert (bus_valid === exp_v) else begin
      bad++; $error("FAIL bus_valid: got %b want %b", bus_valid, exp_v);
    end
    total++;
    assert (owner === exp_o) else begin
      bad++; $error("FAIL owner: got %0d want %0d", owner, exp_o);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1 time unit later.
  task automatic step(input logic [N-1:0] r, input logic c);
    req   = r;
    clear = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    check_outputs();
  endtask

  task automatic expect_sel(input string tag, input int want);
    total++;
    assert (select === SW'(want)) else begin
      bad++; $error("FAIL %s: select got %0d want %0d", tag, select, want);
    end
  endtask

  task automatic expect_grant(input string tag, input logic [N-1:0] want);
    total++;
    assert (grant === want) else begin
      bad++; $error("FAIL %s: grant got %h want %h", tag, grant, want);
    end
  endtask

  logic [N-1:0] rnd_req;

  initial begin
    req   = '0;
    clear = 1'b0;
    m_own = 0; m_sel = 0; m_ptr = N - 1; m_cnt = 0; m_bv = 0; m_ow = 0;

    // Reset and quiet bus.
    step('0, 1'b1);
    expect_grant("reset_grant", '0);
    repeat (20) step('0, 1'b0);

    // Single requester: 4 owned cycles, 1 idle, repeating.
    step('0, 1'b1);
    step(N'(24'h000020), 1'b0);
    expect_sel("single_src5", 5);
    repeat (3) step(N'(24'h000020), 1'b0);
    step(N'(24'h000020), 1'b0);
    expect_grant("single_turnaround", '0);
    repeat (7) step(N'(24'h000020), 1'b0);

    // Two requesters alternate.
    step('0, 1'b1);
    step((N'(1) << 3) | (N'(1) << 20), 1'b0);
    expect_sel("rr_first_3", 3);
    repeat (5) step((N'(1) << 3) | (N'(1) << 20), 1'b0);
    expect_sel("rr_second_20", 20);
    repeat (10) step((N'(1) << 3) | (N'(1) << 20), 1'b0);

    // Wrap-around after source 22.
    step('0, 1'b1);
    step(N'(1) << 22, 1'b0);
    expect_sel("wrap_prev_22", 22);
    step((N'(1) << 1) | (N'(1) << 23), 1'b0);
    step((N'(1) << 1) | (N'(1) << 23), 1'b0);
    expect_sel("wrap_first_23", 23);
    repeat (5) step((N'(1) << 1) | (N'(1) << 23), 1'b0);
    expect_sel("wrap_then_1", 1);

    // Early release shortens the grant.
    step('0, 1'b1);
    step(N'(1) << 7, 1'b0);
    step(N'(1) << 7, 1'b0);
    step('0, 1'b0);
    expect_grant("drop_ends_grant", '0);
    repeat (3) step('0, 1'b0);

    // Clear mid-OWN.
    step('0, 1'b1);
    step(N'(1) << 9, 1'b0);
    step((N'(1) << 2) | (N'(1) << 9), 1'b0);
    step((N'(1) << 2) | (N'(1) << 9), 1'b1);
    expect_grant("clear_mid_own", '0);
    step((N'(1) << 2) | (N'(1) << 9), 1'b0);
    expect_sel("after_clear_2", 2);
    repeat (6) step((N'(1) << 2) | (N'(1) << 9), 1'b0);

    // Randomized traffic with held patterns, single drops and rare clears.
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 3))
        0:       rnd_req = N'($urandom) & N'($urandom) & N'($urandom);
        1:       rnd_req = N'(1) << $urandom_range(0, N - 1);
        2:       rnd_req = N'($urandom);
        default: rnd_req = '0;
      endcase
      repeat ($urandom_range(1, 8)) begin
        if ($urandom_range(0, 5) == 0) rnd_req[$urandom_range(0, N - 1)] = 1'b0;
        step(rnd_req, ($urandom_range(0, 63) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
